collision_pair_scheduler: RTL and testbench
===========================================

Name: collision_pair_scheduler

Overview:
- Sequencer that sweeps every unordered ball pair (i<j) once per start request.
- For each pair it runs a contact test: centre distance squared below threshold, and the balls are approaching.
- Colliding pairs are launched on one shared calc_after_collision_v datapath. The block waits for its done, then writes both new velocities back to the ball state file.
- Sits between the per-frame physics top (start/sweep_done) and the ball register file (read/write ports).

Parameters:
- WIDTH, 32, total fixed-point width (signed).
- FRAC_WIDTH, 30, fractional bits.
- NUM_BALLS, 4, number of balls (>=2).
- IDX_WIDTH, 2, ball index width, >= clog2(NUM_BALLS).
- CONTACT_DIST_SQ, 42949673, (2r)^2 in fixed point (0.04 for FRAC_WIDTH=30).
- TIMEOUT_CYCLES, 255, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: begin sweep
- busy  out  1  high from the accepted start until sweep_done
- sweep_done  out  1  one-cycle pulse at sweep end
- collision_count  out  8  collisions handled in the last sweep; saturates at 255
- rd_idx_a, rd_idx_b  out  IDX_WIDTH  state-file read indices
- rd_x_a, rd_y_a, rd_vx_a, rd_vy_a  in  WIDTH each  ball a state, combinational from rd_idx_a
- rd_x_b, rd_y_b, rd_vx_b, rd_vy_b  in  WIDTH each  ball b state, combinational from rd_idx_b
- calc_rst  out  1  reset to the datapath (restarts it)
- calc_x0, calc_y0, calc_v0_x, calc_v0_y, calc_x1, calc_y1, calc_v1_x, calc_v1_y  out  WIDTH each  datapath operands, registered
- calc_done  in  1  datapath done
- calc_nv0_x, calc_nv0_y, calc_nv1_x, calc_nv1_y  in  WIDTH each  datapath results
- wr_en  out  1  write strobe for both lanes
- wr_idx_a, wr_idx_b  out  IDX_WIDTH  write indices
- wr_vx_a, wr_vy_a, wr_vx_b, wr_vy_b  out  WIDTH each  new velocities
- timeout_err  out  1  sticky error (optional feature only; otherwise tied 0)

Behaviour:
- Reset: state IDLE; busy=0, sweep_done=0, wr_en=0, collision_count=0, indices=0, operand regs=0, calc_rst=1. Reset mid-sweep aborts the sweep with no write and no sweep_done.
- calc_rst = rst OR (state==LAUNCH).
- States:
  - IDLE: on start, set i=0, j=1, clear the count, busy=1, go to LOAD. start is ignored while busy.
  - LOAD: drive rd_idx_a=i, rd_idx_b=j; latch all eight read values into the operand regs.
  - CHECK: dx=x1-x0, dy=y1-y0, dvx=v1_x-v0_x, dvy=v1_y-v0_y.
    - Form 2*WIDTH products; arithmetic shift right by FRAC_WIDTH; sum at WIDTH+1 bits. No wrap.
    - hit = (dx^2+dy^2 < CONTACT_DIST_SQ) AND (dx*dvx+dy*dvy < 0).
    - Coincident centres (dx=dy=0): hit=0.
    - hit goes to LAUNCH; otherwise go to NEXT.
  - LAUNCH: 1 cycle, calc_rst=1, operands held.
  - WAIT: operands held. calc_done is sampled only in WAIT; on calc_done=1, latch the results and go to WRITE.
  - WRITE: wr_en=1 for exactly 1 cycle with idx a=i, b=j. Increment the count (saturating). Go to NEXT.
  - NEXT: j++. If j==NUM_BALLS then i++, j=i+1. If i reaches NUM_BALLS-1, go to DONE; otherwise go to LOAD.
  - DONE: sweep_done=1 for 1 cycle, busy=0, go to IDLE.
- Latency:
  - Non-colliding pair: 3 cycles (LOAD, CHECK, NEXT).
  - Colliding pair: 5 cycles + datapath latency.
  - Sweep total: plus 1 cycle (DONE).
- start during DONE is ignored. start in the same cycle as rst: reset wins.
- Writes use the pair-local snapshot latched in LOAD. Later pairs re-read the file, so they see the updated velocities.

Optional Feature:
- Macro: COLL_SCHED_TIMEOUT_EN.
- Defined:
  - 8-bit counter cleared on entering WAIT, incrementing each WAIT cycle.
  - At TIMEOUT_CYCLES without calc_done: skip WRITE, go to NEXT, set timeout_err.
  - timeout_err is cleared only by rst or by an accepted start.
- Undefined: no counter; WAIT is unbounded; timeout_err constant 0.

Test Plan:
- Reset then idle → busy=0, wr_en=0, calc_rst=1 during rst; start pulse → busy=1 next cycle.
- NUM_BALLS=4, all balls 1.0 apart and stationary → 6 pairs checked, no wr_en; sweep_done exactly 19 cycles after start; collision_count=0.
- Ball0 (0,0) v(0.1,0), ball1 (0.15,0) v(0,0), others far → one launch with calc_rst pulse width 1. Bench datapath model asserts done after 10 cycles. Single wr_en with idx a=0, b=1 carrying the model outputs; count=1.
- Same geometry but ball1 v(0.2,0), i.e. separating → no launch, count=0.
- Reset asserted in WAIT → no wr_en, no sweep_done, state IDLE, busy=0 on the next cycle.
- COLL_SCHED_TIMEOUT_EN with the model never asserting done → after 255 WAIT cycles, no write, timeout_err=1, sweep completes; the next start clears timeout_err.

Source files
------------

// File: rtl/collision_pair_scheduler.sv
// rtl/collision_pair_scheduler.sv - sweeps all ball pairs, resolves contacts on a shared datapath, writes back velocities
// Optional datapath watchdog: define COLL_SCHED_TIMEOUT_EN.
module collision_pair_scheduler #(
  parameter int WIDTH           = 32,
  parameter int FRAC_WIDTH      = 30,
  parameter int NUM_BALLS       = 4,
  parameter int IDX_WIDTH       = 2,
  parameter int CONTACT_DIST_SQ = 42949673,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 sweep_done,
  output logic [7:0]           collision_count,
  output logic [IDX_WIDTH-1:0] rd_idx_a,
  output logic [IDX_WIDTH-1:0] rd_idx_b,
  input  logic [WIDTH-1:0]     rd_x_a,
  input  logic [WIDTH-1:0]     rd_y_a,
  input  logic [WIDTH-1:0]     rd_vx_a,
  input  logic [WIDTH-1:0]     rd_vy_a,
  input  logic [WIDTH-1:0]     rd_x_b,
  input  logic [WIDTH-1:0]     rd_y_b,
  input  logic [WIDTH-1:0]     rd_vx_b,
  input  logic [WIDTH-1:0]     rd_vy_b,
  output logic                 calc_rst,
  output logic [WIDTH-1:0]     calc_x0,
  output logic [WIDTH-1:0]     calc_y0,
  output logic [WIDTH-1:0]     calc_v0_x,
  output logic [WIDTH-1:0]     calc_v0_y,
  output logic [WIDTH-1:0]     calc_x1,
  output logic [WIDTH-1:0]     calc_y1,
  output logic [WIDTH-1:0]     calc_v1_x,
  output logic [WIDTH-1:0]     calc_v1_y,
  input  logic                 calc_done,
  input  logic [WIDTH-1:0]     calc_nv0_x,
  input  logic [WIDTH-1:0]     calc_nv0_y,
  input  logic [WIDTH-1:0]     calc_nv1_x,
  input  logic [WIDTH-1:0]     calc_nv1_y,
  output logic                 wr_en,
  output logic [IDX_WIDTH-1:0] wr_idx_a,
  output logic [IDX_WIDTH-1:0] wr_idx_b,
  output logic [WIDTH-1:0]     wr_vx_a,
  output logic [WIDTH-1:0]     wr_vy_a,
  output logic [WIDTH-1:0]     wr_vx_b,
  output logic [WIDTH-1:0]     wr_vy_b,
  output logic                 timeout_err
);

  localparam int PW = 2 * WIDTH + 2;
  localparam logic [IDX_WIDTH-1:0] LAST_I = IDX_WIDTH'(NUM_BALLS - 2);
  localparam logic [IDX_WIDTH-1:0] LAST_J = IDX_WIDTH'(NUM_BALLS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_LAUNCH, S_WAIT, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t                 state_q;
  logic [IDX_WIDTH-1:0]   i_q, j_q;
  logic                   busy_q, done_q, wr_en_q;
  logic [7:0]             count_q;
  logic signed [WIDTH-1:0] x0_q, y0_q, v0x_q, v0y_q, x1_q, y1_q, v1x_q, v1y_q;
  logic [WIDTH-1:0]       nv0x_q, nv0y_q, nv1x_q, nv1y_q;

  // Differences carry one extra bit and products are full width, so nothing wraps.
  logic signed [WIDTH:0]  dx, dy, dvx, dvy;
  logic signed [PW-1:0]   sq_x, sq_y, dot_x, dot_y;
  logic signed [PW:0]     dist_sq, dot;
  logic                   hit;

  assign dx    = (WIDTH+1)'(x1_q)  - (WIDTH+1)'(x0_q);
  assign dy    = (WIDTH+1)'(y1_q)  - (WIDTH+1)'(y0_q);
  assign dvx   = (WIDTH+1)'(v1x_q) - (WIDTH+1)'(v0x_q);
  assign dvy   = (WIDTH+1)'(v1y_q) - (WIDTH+1)'(v0y_q);
  assign sq_x  = (PW'(dx) * PW'(dx))  >>> FRAC_WIDTH;
  assign sq_y  = (PW'(dy) * PW'(dy))  >>> FRAC_WIDTH;
  assign dot_x = (PW'(dx) * PW'(dvx)) >>> FRAC_WIDTH;
  assign dot_y = (PW'(dy) * PW'(dvy)) >>> FRAC_WIDTH;
  assign dist_sq = (PW+1)'(sq_x) + (PW+1)'(sq_y);
  assign dot     = (PW+1)'(dot_x) + (PW+1)'(dot_y);
  assign hit = (dist_sq < (PW+1)'(CONTACT_DIST_SQ)) && dot[PW] && ((dx != '0) || (dy != '0));

`ifdef COLL_SCHED_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q <= '0; j_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; wr_en_q <= 1'b0;
      count_q <= 8'd0;
      x0_q <= '0; y0_q <= '0; v0x_q <= '0; v0y_q <= '0;
      x1_q <= '0; y1_q <= '0; v1x_q <= '0; v1y_q <= '0;
      nv0x_q <= '0; nv0y_q <= '0; nv1x_q <= '0; nv1y_q <= '0;
`ifdef COLL_SCHED_TIMEOUT_EN
      wait_cnt_q <= 8'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          i_q <= '0;
          j_q <= IDX_WIDTH'(1);
          count_q <= 8'd0;
          busy_q <= 1'b1;
`ifdef COLL_SCHED_TIMEOUT_EN
          timeout_err_q <= 1'b0;
`endif
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          x0_q <= rd_x_a; y0_q <= rd_y_a; v0x_q <= rd_vx_a; v0y_q <= rd_vy_a;
          x1_q <= rd_x_b; y1_q <= rd_y_b; v1x_q <= rd_vx_b; v1y_q <= rd_vy_b;
          state_q <= S_CHECK;
        end
        S_CHECK: state_q <= hit ? S_LAUNCH : S_NEXT;
        S_LAUNCH: begin
`ifdef COLL_SCHED_TIMEOUT_EN
          wait_cnt_q <= 8'd0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (calc_done) begin
            nv0x_q <= calc_nv0_x; nv0y_q <= calc_nv0_y;
            nv1x_q <= calc_nv1_x; nv1y_q <= calc_nv1_y;
            wr_en_q <= 1'b1;
            state_q <= S_WRITE;
          end
`ifdef COLL_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_q <= 1'b1;
            state_q <= S_NEXT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        S_WRITE: begin
          if (count_q != 8'hFF) count_q <= count_q + 8'd1;
          state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (j_q != LAST_J) begin
            j_q <= j_q + IDX_WIDTH'(1);
            state_q <= S_LOAD;
          end else if (i_q == LAST_I) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            i_q <= i_q + IDX_WIDTH'(1);
            j_q <= i_q + IDX_WIDTH'(2);
            state_q <= S_LOAD;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign sweep_done      = done_q;
  assign collision_count = count_q;
  assign rd_idx_a  = i_q;
  assign rd_idx_b  = j_q;
  assign calc_rst  = rst | (state_q == S_LAUNCH);
  assign calc_x0   = x0_q;
  assign calc_y0   = y0_q;
  assign calc_v0_x = v0x_q;
  assign calc_v0_y = v0y_q;
  assign calc_x1   = x1_q;
  assign calc_y1   = y1_q;
  assign calc_v1_x = v1x_q;
  assign calc_v1_y = v1y_q;
  assign wr_en     = wr_en_q;
  assign wr_idx_a  = i_q;
  assign wr_idx_b  = j_q;
  assign wr_vx_a   = nv0x_q;
  assign wr_vy_a   = nv0y_q;
  assign wr_vx_b   = nv1x_q;
  assign wr_vy_b   = nv1y_q;

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// tb/tb_collision_pair_scheduler.sv - directed sweep vectors against a ball file and datapath model
module tb_collision_pair_scheduler;

  localparam logic [31:0] ONE = 32'h4000_0000;
  localparam logic [31:0] P1  = 32'd107374182;
  localparam logic [31:0] P15 = 32'd161061274;
  localparam logic [31:0] P2  = 32'd214748365;
  localparam logic [31:0] P3  = 32'd322122547;
  localparam logic [31:0] NP1 = 32'hF999_999A;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, sweep_done, calc_rst, calc_done, wr_en, timeout_err;
  logic [7:0] collision_count;
  logic [1:0] rd_idx_a, rd_idx_b, wr_idx_a, wr_idx_b;
  logic [31:0] rd_x_a, rd_y_a, rd_vx_a, rd_vy_a, rd_x_b, rd_y_b, rd_vx_b, rd_vy_b;
  logic [31:0] calc_x0, calc_y0, calc_v0_x, calc_v0_y, calc_x1, calc_y1, calc_v1_x, calc_v1_y;
  logic [31:0] calc_nv0_x, calc_nv0_y, calc_nv1_x, calc_nv1_y;
  logic [31:0] wr_vx_a, wr_vy_a, wr_vx_b, wr_vy_b;

  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  collision_pair_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .sweep_done(sweep_done),
    .collision_count(collision_count), .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
    .rd_x_a(rd_x_a), .rd_y_a(rd_y_a), .rd_vx_a(rd_vx_a), .rd_vy_a(rd_vy_a),
    .rd_x_b(rd_x_b), .rd_y_b(rd_y_b), .rd_vx_b(rd_vx_b), .rd_vy_b(rd_vy_b),
    .calc_rst(calc_rst), .calc_x0(calc_x0), .calc_y0(calc_y0), .calc_v0_x(calc_v0_x),
    .calc_v0_y(calc_v0_y), .calc_x1(calc_x1), .calc_y1(calc_y1), .calc_v1_x(calc_v1_x),
    .calc_v1_y(calc_v1_y), .calc_done(calc_done), .calc_nv0_x(calc_nv0_x),
    .calc_nv0_y(calc_nv0_y), .calc_nv1_x(calc_nv1_x), .calc_nv1_y(calc_nv1_y),
    .wr_en(wr_en), .wr_idx_a(wr_idx_a), .wr_idx_b(wr_idx_b), .wr_vx_a(wr_vx_a),
    .wr_vy_a(wr_vy_a), .wr_vx_b(wr_vx_b), .wr_vy_b(wr_vy_b), .timeout_err(timeout_err)
  );

  // Ball state file: combinational reads, writes on the clock edge.
  logic [31:0] bx[4], by[4], bvx[4], bvy[4];
  assign rd_x_a = bx[rd_idx_a];  assign rd_y_a = by[rd_idx_a];
  assign rd_vx_a = bvx[rd_idx_a]; assign rd_vy_a = bvy[rd_idx_a];
  assign rd_x_b = bx[rd_idx_b];  assign rd_y_b = by[rd_idx_b];
  assign rd_vx_b = bvx[rd_idx_b]; assign rd_vy_b = bvy[rd_idx_b];

  always @(posedge clk) begin
    if (wr_en) begin
      bvx[wr_idx_a] = wr_vx_a; bvy[wr_idx_a] = wr_vy_a;
      bvx[wr_idx_b] = wr_vx_b; bvy[wr_idx_b] = wr_vy_b;
    end
  end

  // Datapath model: done 10 cycles after calc_rst drops; results are tagged operand swaps.
  int  mcnt = 0;
  bit  never_done = 1'b0;
  always @(posedge clk) begin
    if (calc_rst) mcnt <= 0;
    else if (mcnt < 20) mcnt <= mcnt + 1;
  end
  assign calc_done  = !never_done && (mcnt >= 10);
  assign calc_nv0_x = calc_v1_x + 32'd1;
  assign calc_nv0_y = calc_v1_y + 32'd2;
  assign calc_nv1_x = calc_v0_x + 32'd3;
  assign calc_nv1_y = calc_v0_y + 32'd4;

  typedef struct {
    logic [3:0][31:0] x, y, vx, vy;
    int restart_at, exp_count, exp_launch, exp_cycles, exp_terr, wa, wb;
    logic [31:0] evxa, evya, evxb, evyb;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t base_vec();
    vec_t v;
    v.x = {ONE, 32'd0, ONE, 32'd0};
    v.y = {ONE, ONE, 32'd0, 32'd0};
    v.vx = '0; v.vy = '0;
    v.restart_at = 0; v.exp_count = 0; v.exp_launch = 0; v.exp_cycles = 19; v.exp_terr = 0;
    v.wa = 0; v.wb = 0; v.evxa = 0; v.evya = 0; v.evxb = 0; v.evyb = 0;
    return v;
  endfunction

  function automatic vec_t approach_vec();
    vec_t v = base_vec();
    v.x[0] = 32'd0; v.y[0] = 32'd0; v.vx[0] = P1;
    v.x[1] = P15;   v.y[1] = 32'd0;
    v.exp_count = 1; v.exp_launch = 1; v.exp_cycles = 32; v.wa = 0; v.wb = 1;
    v.evxa = 32'd1; v.evya = 32'd2; v.evxb = P1 + 32'd3; v.evyb = 32'd4;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0, wr_n = 0, rst_hi = 0, rst_run = 0, rst_max = 0, la = -1, lb = -1;
    logic [31:0] lvxa = 0, lvya = 0, lvxb = 0, lvyb = 0;
    bit got = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bx[b] = v.x[b]; by[b] = v.y[b]; bvx[b] = v.vx[b]; bvy[b] = v.vy[b];
    end
    start = 1'b1;
    while (!got && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
      end
      if (v.restart_at > 0 && cyc == v.restart_at) start = 1'b1;
      if (v.restart_at > 0 && cyc == v.restart_at + 1) start = 1'b0;
      if (calc_rst) begin
        rst_hi++; rst_run++;
        if (rst_run > rst_max) rst_max = rst_run;
      end else rst_run = 0;
      if (wr_en) begin
        wr_n++; la = wr_idx_a; lb = wr_idx_b;
        lvxa = wr_vx_a; lvya = wr_vy_a; lvxb = wr_vx_b; lvyb = wr_vy_b;
      end
      if (sweep_done) got = 1'b1;
    end
    check({tag, " sweep_done_seen"}, got, 1);
    check({tag, " sweep_cycles"}, cyc, v.exp_cycles);
    check({tag, " collision_count"}, collision_count, v.exp_count);
    check({tag, " wr_en_count"}, wr_n, v.exp_count);
    check({tag, " calc_rst_cycles"}, rst_hi, v.exp_launch);
    check({tag, " busy_in_done"}, busy, 0);
    check({tag, " timeout_err"}, timeout_err, v.exp_terr);
    if (v.exp_launch > 0) check({tag, " calc_rst_width"}, rst_max, 1);
    if (v.exp_count > 0) begin
      check({tag, " wr_idx_a"}, la, v.wa);
      check({tag, " wr_idx_b"}, lb, v.wb);
      check({tag, " wr_vx_a"}, lvxa, v.evxa);
      check({tag, " wr_vy_a"}, lvya, v.evya);
      check({tag, " wr_vx_b"}, lvxb, v.evxb);
      check({tag, " wr_vy_b"}, lvyb, v.evyb);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " start_in_done_ignored"}, busy, 0);
    @(posedge clk); #1;
    check({tag, " idle_after_done"}, busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    vecs[0] = base_vec();
    vecs[1] = base_vec(); vecs[1].restart_at = 5;
    vecs[2] = approach_vec();
    vecs[3] = approach_vec(); vecs[3].vx[1] = P2;
    vecs[3].exp_count = 0; vecs[3].exp_launch = 0; vecs[3].exp_cycles = 19;
    vecs[4] = approach_vec(); vecs[4].x[1] = 32'd0;
    vecs[4].exp_count = 0; vecs[4].exp_launch = 0; vecs[4].exp_cycles = 19;
    vecs[5] = base_vec();
    vecs[5].x[3] = 32'd0; vecs[5].y[3] = ONE + P15; vecs[5].vy[3] = NP1;
    vecs[5].exp_count = 1; vecs[5].exp_launch = 1; vecs[5].exp_cycles = 32; vecs[5].wa = 2; vecs[5].wb = 3;
    vecs[5].evxa = 32'd1; vecs[5].evya = NP1 + 32'd2; vecs[5].evxb = 32'd3; vecs[5].evyb = 32'd4;
    vecs[6] = approach_vec(); vecs[6].x[2] = P3; vecs[6].y[2] = 32'd0;
    vecs[6].exp_count = 2; vecs[6].exp_launch = 2; vecs[6].exp_cycles = 45; vecs[6].wa = 1; vecs[6].wb = 2;
    vecs[6].evxa = 32'd1; vecs[6].evya = 32'd2; vecs[6].evxb = P1 + 32'd6; vecs[6].evyb = 32'd8;

    for (int b = 0; b < 4; b++) begin
      bx[b] = 0; by[b] = 0; bvx[b] = 0; bvy[b] = 0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset wr_en", wr_en, 0);
    check("reset sweep_done", sweep_done, 0);
    check("reset calc_rst", calc_rst, 1);
    check("reset collision_count", collision_count, 0);
    check("reset rd_idx_b", rd_idx_b, 0);
    check("reset calc_x1", calc_x1, 0);
    check("reset timeout_err", timeout_err, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_with_rst busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle calc_rst", calc_rst, 0);
    check("idle busy", busy, 0);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // Reset while waiting on the datapath aborts the sweep silently.
    for (int b = 0; b < 4; b++) begin
      bx[b] = vecs[2].x[b]; by[b] = vecs[2].y[b]; bvx[b] = vecs[2].vx[b]; bvy[b] = vecs[2].vy[b];
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    while (!calc_rst && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    check("abort launch_seen", calc_rst, 1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort wr_en", wr_en, 0);
    check("abort sweep_done", sweep_done, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (wr_en || sweep_done || busy) cnt++;
    end
    check("abort stays_idle", cnt, 0);
    check("abort ball0_vx_untouched", bvx[0], P1);

`ifdef COLL_SCHED_TIMEOUT_EN
    never_done = 1'b1;
    begin
      vec_t t = approach_vec();
      t.exp_count = 0; t.exp_launch = 1; t.exp_cycles = 275; t.exp_terr = 1;
      run_vec(t, "timeout");
    end
    never_done = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("timeout cleared_by_start", timeout_err, 0);
    cnt = 0;
    while (!sweep_done && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    check("timeout next_sweep_done", sweep_done, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
